// File: rtl/button_event_decoder_if.sv
// Signal bundle between a debounced button source and the event decoder.
// Events are single-cycle pulses with no back-pressure: a consumer must sample them every cycle.
interface button_event_decoder_if;
  logic btn;
  logic short_click;
  logic double_click;
  logic long_press;
  logic repeat_tick;
  logic busy;

  modport master (
    output btn,
    input  short_click,
    input  double_click,
    input  long_press,
    input  repeat_tick,
    input  busy
  );

  modport slave (
    input  btn,
    output short_click,
    output double_click,
    output long_press,
    output repeat_tick,
    output busy
  );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into registered one-cycle pulses for click,
// double click, long press and hold-to-repeat, using one shared sample counter.
module button_event_decoder #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int DBL_CYCLES    = 15_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int CNT_W         = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  button_event_decoder_if.slave bus,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    ST_ARM    = 3'd0,
    ST_IDLE   = 3'd1,
    ST_PRESS1 = 3'd2,
    ST_WAIT2  = 3'd3,
    ST_LONG   = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             busy_q, busy_d;

  // ARM is the reset state so a button held through reset is ignored until released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ARM;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ARM: begin
        cnt_d = '0;
        if (!bus.btn) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.btn) begin
          state_d = ST_PRESS1;
          cnt_d   = CNT_ONE;
        end
      end
      ST_PRESS1: begin
        if (!bus.btn) begin
          state_d = ST_WAIT2;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == LONG_LAST) begin
          state_d = ST_LONG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_WAIT2: begin
        // A press on the expiry edge still counts as the second click.
        if (bus.btn) begin
          state_d = ST_ARM;
          cnt_d   = '0;
        end else if (cnt_q == DBL_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_LONG: begin
        if (!bus.btn) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == REP_LAST) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_ARM;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    short_d  = (state_q == ST_WAIT2)  && !bus.btn && (cnt_q == DBL_LAST);
    double_d = (state_q == ST_WAIT2)  &&  bus.btn;
    long_d   = (state_q == ST_PRESS1) &&  bus.btn && (cnt_q == LONG_LAST);
    repeat_d = (state_q == ST_LONG)   &&  bus.btn && (cnt_q == REP_LAST);
    busy_d   = (state_d != ST_IDLE);
  end

  assign bus.short_click  = short_q;
  assign bus.double_click = double_q;
  assign bus.long_press   = long_q;
  assign bus.repeat_tick  = repeat_q;
  assign bus.busy         = busy_q;
  assign state_o          = state_q;

endmodule
